mc_control_unit: RTL and testbench

//  Multi-cycle control FSM for the cpu datapath. Sequences IF/ID/EXE/MEM/WB per

---
 rtl/mc_control_unit_pkg.sv | 48 ++++
 rtl/mc_control_unit_decode.sv | 50 +++++
 rtl/mc_control_unit.sv | 165 ++++++++++++++++
 tb/tb_mc_control_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Contents: one-hot state codes, instruction classes, opcode/funct codes,
// ALU operation codes and PC source select codes.
package mc_control_unit_pkg;

  typedef enum logic [4:0] {
    ST_IF  = 5'b00001,
    ST_ID  = 5'b00010,
    ST_EXE = 5'b00100,
    ST_MEM = 5'b01000,
    ST_WB  = 5'b10000
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_LW    = 3'd1,
    CLS_SW    = 3'd2,
    CLS_BR    = 3'd3,
    CLS_J     = 3'd4,
    CLS_ILL   = 3'd5
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_unit_decode.sv
// Combinational instruction decoder.
// Ports:
//   opcode, funct  in  IR fields
//   instr_class    out instruction class (R-type, LW, SW, branch, jump, illegal)
//   alu_op         out ALU operation the instruction needs in EXE
//   br_ne          out 1 when the branch is BNE (taken on not-equal)
module mc_decode
  import mc_control_unit_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t instr_class,
  output logic [2:0]   alu_op,
  output logic         br_ne
);

  always_comb begin
    instr_class = CLS_ILL;
    alu_op      = ALU_ADD;
    br_ne       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        instr_class = CLS_RTYPE;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: instr_class = CLS_ILL;
        endcase
      end
      OP_LW:  instr_class = CLS_LW;
      OP_SW:  instr_class = CLS_SW;
      OP_BEQ: begin
        instr_class = CLS_BR;
        alu_op      = ALU_SUB;
      end
      OP_BNE: begin
        instr_class = CLS_BR;
        alu_op      = ALU_SUB;
        br_ne       = 1'b1;
      end
      OP_J:    instr_class = CLS_J;
      default: instr_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the cpu datapath. Sequences IF/ID/EXE/MEM/WB,
// drives datapath enables and mux selects, counts retired instructions.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   opcode, funct      IR fields (meaningful from ID onward)
//   equal, res_zero    ALU flags (res_zero is not used for branching)
//   current_state      one-hot state
//   pc_write .. pc_src datapath enables and mux selects
//   illegal_op         one-cycle pulse in ID for an undecodable instruction
//   instr_count        retired instruction count, wraps modulo 2^CNT_W
//
// state | meaning
// IF    | fetch: load IR, PC <= PC+4
// ID    | decode; J and illegal instructions finish here
// EXE   | ALU operation; branches resolve and finish here
// MEM   | data memory access; SW finishes here
// WB    | register file write; R-type and LW finish here
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             equal,
  input  logic             res_zero,
  output logic [4:0]       current_state,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t       state;
  state_t       state_nxt;
  logic         retire;
  instr_class_t instr_class;
  logic [2:0]   dec_alu_op;
  logic         br_ne;
  logic         unused_res_zero;

  assign unused_res_zero = res_zero;
  assign current_state   = state;

  mc_decode u_decode (
    .opcode      (opcode),
    .funct       (funct),
    .instr_class (instr_class),
    .alu_op      (dec_alu_op),
    .br_ne       (br_ne)
  );

  always_comb begin
    state_nxt  = ST_IF;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    pc_src     = PC_SRC_SEQ;
    illegal_op = 1'b0;
    case (state)
      ST_IF: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        state_nxt = ST_ID;
      end
      ST_ID: begin
        case (instr_class)
          CLS_J: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            retire   = 1'b1;
          end
          CLS_ILL: illegal_op = 1'b1;
          default: state_nxt  = ST_EXE;
        endcase
      end
      ST_EXE: begin
        case (instr_class)
          CLS_RTYPE: begin
            alu_op    = dec_alu_op;
            state_nxt = ST_WB;
          end
          CLS_LW, CLS_SW: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            state_nxt = ST_MEM;
          end
          CLS_BR: begin
            alu_op   = ALU_SUB;
            pc_src   = PC_SRC_BRANCH;
            // BNE inverts the taken condition
            pc_write = equal ^ br_ne;
            retire   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        case (instr_class)
          CLS_LW: begin
            mem_read  = 1'b1;
            state_nxt = ST_WB;
          end
          CLS_SW: begin
            mem_write = 1'b1;
            retire    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        reg_dst    = (instr_class == CLS_RTYPE);
        mem_to_reg = (instr_class == CLS_LW);
      end
      default: ;  // non-one-hot encoding: recover to IF with nothing enabled
    endcase

    // Keep the datapath quiet for the whole time reset is asserted,
    // not just after the state register has been cleared.
    if (!rst_n) begin
      retire     = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = ALU_ADD;
      pc_src     = PC_SRC_SEQ;
      illegal_op = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IF;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
`timescale 1ns/1ps
module tb_mc_control_unit;

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BR = 3, C_J = 4, C_ILL = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode = '0, funct = '0;
  logic equal = 1'b0, res_zero = 1'b0;

  logic [4:0]  cs_a, cs_b;
  logic        pcw_a, irw_a, mr_a, mw_a, rw_a, rd_a, m2r_a, asb_a, ill_a;
  logic        pcw_b, irw_b, mr_b, mw_b, rw_b, rd_b, m2r_b, asb_b, ill_b;
  logic [2:0]  aop_a, aop_b;
  logic [1:0]  psrc_a, psrc_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_cnt = '0;

  always #5 clk = ~clk;

  mc_control_unit #(.CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .equal(equal),
    .res_zero(res_zero), .current_state(cs_a), .pc_write(pcw_a), .ir_write(irw_a),
    .mem_read(mr_a), .mem_write(mw_a), .reg_write(rw_a), .reg_dst(rd_a),
    .mem_to_reg(m2r_a), .alu_src_b(asb_a), .alu_op(aop_a), .pc_src(psrc_a),
    .illegal_op(ill_a), .instr_count(cnt_a)
  );

  mc_control_unit #(.CNT_W(4)) u_dut_w4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .equal(equal),
    .res_zero(res_zero), .current_state(cs_b), .pc_write(pcw_b), .ir_write(irw_b),
    .mem_read(mr_b), .mem_write(mw_b), .reg_write(rw_b), .reg_dst(rd_b),
    .mem_to_reg(m2r_b), .alu_src_b(asb_b), .alu_op(aop_b), .pc_src(psrc_b),
    .illegal_op(ill_b), .instr_count(cnt_b)
  );

  // {state, pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
  //  mem_to_reg, alu_src_b, alu_op, pc_src, illegal_op}
  logic [18:0] act_a, act_b;
  assign act_a = {cs_a, pcw_a, irw_a, mr_a, mw_a, rw_a, rd_a, m2r_a, asb_a, aop_a, psrc_a, ill_a};
  assign act_b = {cs_b, pcw_b, irw_b, mr_b, mw_b, rw_b, rd_b, m2r_b, asb_b, aop_b, psrc_b, ill_b};

  localparam logic [18:0] RESET_VEC = {5'b00001, 14'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic int alu_of(input logic [5:0] fn);
    case (fn)
      6'h20: return 0;
      6'h22: return 1;
      6'h24: return 2;
      6'h25: return 3;
      6'h26: return 4;
      6'h2A: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (alu_of(fn) >= 0) ? C_R : C_ILL;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04, 6'h05: return C_BR;
      6'h02: return C_J;
      default: return C_ILL;
    endcase
  endfunction

  function automatic int latency(input int cls);
    case (cls)
      C_R:  return 4;
      C_LW: return 5;
      C_SW: return 4;
      C_BR: return 3;
      default: return 2;
    endcase
  endfunction

  // Phase index 0..4 = IF, ID, EXE, MEM, WB; R-type skips MEM.
  function automatic int phase_at(input int cls, input int k);
    return (cls == C_R && k == 3) ? 4 : k;
  endfunction

  function automatic logic [18:0] expect_out(input int ph, input int cls,
                                             input logic [5:0] op, input logic [5:0] fn,
                                             input bit eq);
    logic [4:0] st;
    bit pcw = 0, irw = 0, mr = 0, mw = 0, rw = 0, rd = 0, m2r = 0, asb = 0, ill = 0;
    logic [2:0] aop = 3'd0;
    logic [1:0] psrc = 2'd0;
    st = 5'b00001 << ph;
    case (ph)
      0: begin irw = 1; pcw = 1; end
      1: begin
        if (cls == C_J) begin pcw = 1; psrc = 2'b10; end
        else if (cls == C_ILL) ill = 1;
      end
      2: begin
        if (cls == C_R) aop = 3'(alu_of(fn));
        else if (cls == C_LW || cls == C_SW) asb = 1;
        else if (cls == C_BR) begin
          aop = 3'd1;
          psrc = 2'b01;
          pcw = (op == 6'h05) ? !eq : eq;
        end
      end
      3: begin mr = (cls == C_LW); mw = (cls == C_SW); end
      4: begin rw = 1; rd = (cls == C_R); m2r = (cls == C_LW); end
      default: ;
    endcase
    return {st, pcw, irw, mr, mw, rw, rd, m2r, asb, aop, psrc, ill};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the last cycle,
  // or at the negedge of cycle stop_k if stop_k >= 0 (instruction not retired).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int eq_force, input int stop_k);
    int cls, n, ph;
    bit e;
    logic [18:0] exp;
    cls = classify(op, fn);
    n = latency(cls);
    for (int k = 0; k < n; k++) begin
      ph = phase_at(cls, k);
      e = (eq_force < 0) ? 1'($urandom_range(0, 1)) : 1'(eq_force);
      if (ph == 0) begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end else begin
        opcode = op;
        funct  = fn;
      end
      equal    = e;
      res_zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp = expect_out(ph, cls, op, fn, e);
      check("outputs", {13'b0, act_a}, {13'b0, exp});
      check("outputs_w4", {13'b0, act_b}, {13'b0, exp});
      check("instr_count", cnt_a, model_cnt);
      check("instr_count_w4", {28'b0, cnt_b}, {28'b0, model_cnt[3:0]});
      if (k == stop_k) return;
      @(posedge clk);
      #1;
    end
    if (cls != C_ILL) model_cnt++;
  endtask

  task automatic check_reset_state();
    check("reset_outputs", {13'b0, act_a}, {13'b0, RESET_VEC});
    check("reset_outputs_w4", {13'b0, act_b}, {13'b0, RESET_VEC});
    check("reset_count", cnt_a, 32'd0);
    check("reset_count_w4", {28'b0, cnt_b}, 32'd0);
  endtask

  logic [5:0] legal_fn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};

  initial begin
    int r;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_cnt = '0;

    // Directed instructions with hand-computed count milestones
    run_instr(6'h00, 6'h20, -1, -1);          // ADD
    check("count_after_add", cnt_a, 32'd1);
    run_instr(6'h23, 6'h00, -1, -1);          // LW
    run_instr(6'h2B, 6'h00, -1, -1);          // SW
    check("count_after_lw_sw", cnt_a, 32'd3);
    run_instr(6'h04, 6'h00, 1, -1);           // BEQ taken
    run_instr(6'h05, 6'h00, 1, -1);           // BNE not taken
    run_instr(6'h02, 6'h00, -1, -1);          // J
    check("count_after_br_j", cnt_a, 32'd6);
    run_instr(6'h3F, 6'h00, -1, -1);          // illegal opcode
    run_instr(6'h00, 6'h3F, -1, -1);          // R-type with bad funct
    check("count_after_illegal", cnt_a, 32'd6);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: run_instr(6'h00, legal_fn[$urandom_range(0, 5)], -1, -1);
        3: run_instr(6'h23, 6'($urandom), -1, -1);
        4: run_instr(6'h2B, 6'($urandom), -1, -1);
        5: run_instr(6'h04, 6'($urandom), -1, -1);
        6: run_instr(6'h05, 6'($urandom), -1, -1);
        7: run_instr(6'h02, 6'($urandom), -1, -1);
        8: run_instr(6'($urandom), 6'($urandom), -1, -1);
        default: run_instr(6'h00, 6'($urandom), -1, -1);
      endcase
    end

    // Reset asserted in the middle of EXE and held for three cycles
    run_instr(6'h00, 6'h20, -1, 2);
    #2 rst_n = 1'b0;
    #1 check_reset_state();
    repeat (3) begin
      @(negedge clk);
      check_reset_state();
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_cnt = '0;

    // 17 ADDs: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) run_instr(6'h00, 6'h20, -1, -1);
    check("wrap_count_w4", {28'b0, cnt_b}, 32'd1);
    check("count_after_17", cnt_a, 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
